controle_execucao: RTL and testbench

- Run-control sequencer for the single-cycle RISC-V datapath.
- Generates the datapath reset and a per-cycle commit enable (`habilita_pc`) from run, step and halt commands.
- Stops execution on EBREAK/ECALL and optionally on a PC breakpoint. Counts retired instructions.
- Sits between the top level/debug host and the datapath. The datapath gates PC update, register-file write and data-memory write with `habilita_pc`.

---
 rtl/controle_execucao.sv | 138 +++++++++++++
 tb/tb_controle_execucao.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/controle_execucao.sv
// Run-control sequencer for the single-cycle RISC-V datapath: datapath reset, commit enable,
// stop on EBREAK/ECALL, retired-instruction count. Define CONTROLE_BREAKPOINT_EN for PC breakpoints.
module controle_execucao #(
    parameter int unsigned RESET_HOLD = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_halt,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valido,
    input  logic [31:0]      pc_atual,
    input  logic [31:0]      instrucao,
    output logic             reset_datapath,
    output logic             habilita_pc,
    output logic [2:0]       estado,
    output logic [CNT_W-1:0] contador_instr,
    output logic [1:0]       motivo_parada
);

    localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);

    localparam logic [31:0] InstrEbreak = 32'h0010_0073;
    localparam logic [31:0] InstrEcall  = 32'h0000_0073;

    localparam logic [1:0] MotivoNenhum = 2'd0;
    localparam logic [1:0] MotivoHalt   = 2'd1;
    localparam logic [1:0] MotivoTrap   = 2'd2;
    localparam logic [1:0] MotivoBp     = 2'd3;

    typedef enum logic [2:0] {
        StInicio     = 3'd0,
        StOcioso     = 3'd1,
        StExecutando = 3'd2,
        StPasso      = 3'd3,
        StParado     = 3'd4
    } estado_e;

    estado_e          estado_q;
    logic [HoldW-1:0] hold_q;
    logic             reset_dp_q;
    logic             skip_q;
    logic [1:0]       motivo_q;
    logic [CNT_W-1:0] contador_q;

    logic ebreak, ecall, trap, bp_hit, parar;
    logic [1:0] motivo_stop;

    assign ebreak = (instrucao == InstrEbreak);
    assign ecall  = (instrucao == InstrEcall);
    assign trap   = ebreak | ecall;

`ifdef CONTROLE_BREAKPOINT_EN
    assign bp_hit = bp_valido && (pc_atual == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr, bp_valido, pc_atual};
    assign bp_hit    = 1'b0;
`endif

    // skip lets the first instruction after a resume pass the stop that caused the halt
    assign parar       = (trap | bp_hit) && !skip_q;
    assign motivo_stop = trap ? MotivoTrap : MotivoBp;
    assign habilita_pc = ((estado_q == StExecutando) || (estado_q == StPasso)) && !parar;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= StInicio;
            hold_q     <= '0;
            reset_dp_q <= 1'b1;
            skip_q     <= 1'b0;
            motivo_q   <= MotivoNenhum;
            contador_q <= '0;
        end else begin
            skip_q <= 1'b0;
            if (habilita_pc && (contador_q != '1)) begin
                contador_q <= contador_q + CNT_W'(1);
            end
            case (estado_q)
                StInicio: begin
                    if (hold_q == HoldLast) begin
                        hold_q     <= '0;
                        reset_dp_q <= 1'b0;
                        estado_q   <= StOcioso;
                    end else begin
                        hold_q <= hold_q + HoldW'(1);
                    end
                end
                StOcioso: begin
                    if (cmd_step) begin
                        estado_q <= StPasso;
                    end else if (cmd_run) begin
                        estado_q <= StExecutando;
                    end
                end
                StExecutando: begin
                    if (parar) begin
                        estado_q <= StParado;
                        motivo_q <= motivo_stop;
                    end else if (cmd_halt) begin
                        estado_q <= StParado;
                        motivo_q <= MotivoHalt;
                    end
                end
                StPasso: begin
                    if (parar) begin
                        estado_q <= StParado;
                        motivo_q <= motivo_stop;
                    end else begin
                        estado_q <= StOcioso;
                    end
                end
                StParado: begin
                    if (cmd_step || cmd_run) begin
                        estado_q <= cmd_step ? StPasso : StExecutando;
                        skip_q   <= 1'b1;
                        motivo_q <= MotivoNenhum;
                    end
                end
                default: begin
                    estado_q   <= StInicio;
                    hold_q     <= '0;
                    reset_dp_q <= 1'b1;
                    motivo_q   <= MotivoNenhum;
                end
            endcase
        end
    end

    assign reset_datapath = reset_dp_q;
    assign estado         = estado_q;
    assign contador_instr = contador_q;
    assign motivo_parada  = motivo_q;

endmodule

// File: tb/tb_controle_execucao.sv
// Self-checking bench for controle_execucao: directed vector table, reset sequences and a
// randomized run against a behavioural model. Honours CONTROLE_BREAKPOINT_EN like the design.
module tb_controle_execucao;

    localparam int unsigned Hold = 4;
    localparam logic [31:0] Nop    = 32'h0000_0013;
    localparam logic [31:0] Ebreak = 32'h0010_0073;
    localparam logic [31:0] Ecall  = 32'h0000_0073;
`ifdef CONTROLE_BREAKPOINT_EN
    localparam int Bp = 1;
`else
    localparam int Bp = 0;
`endif
    localparam int MInit = 0, MIdle = 1, MRun = 2, MStep = 3, MHalted = 4;
    localparam int NV = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cmd_run, cmd_step, cmd_halt, bp_valido;
    logic [31:0] bp_addr, pc_atual, instrucao;
    logic        reset_datapath, habilita_pc;
    logic [2:0]  estado;
    logic [31:0] contador_instr;
    logic [1:0]  motivo_parada;
    logic        s_rd, s_en;
    logic [2:0]  s_st;
    logic [2:0]  s_cnt;
    logic [1:0]  s_mot;

    controle_execucao #(.RESET_HOLD(Hold), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
        .bp_addr(bp_addr), .bp_valido(bp_valido), .pc_atual(pc_atual), .instrucao(instrucao),
        .reset_datapath(reset_datapath), .habilita_pc(habilita_pc), .estado(estado),
        .contador_instr(contador_instr), .motivo_parada(motivo_parada)
    );

    // Narrow counter copy: same control behaviour, counter saturates at 7
    controle_execucao #(.RESET_HOLD(Hold), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
        .bp_addr(bp_addr), .bp_valido(bp_valido), .pc_atual(pc_atual), .instrucao(instrucao),
        .reset_datapath(s_rd), .habilita_pc(s_en), .estado(s_st),
        .contador_instr(s_cnt), .motivo_parada(s_mot)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input bit en, input bit rd,
                             input int cnt, input int mot);
        check({tag, ".estado"}, 32'(estado), 32'(st));
        check({tag, ".habilita_pc"}, 32'(habilita_pc), 32'(en));
        check({tag, ".reset_datapath"}, 32'(reset_datapath), 32'(rd));
        check({tag, ".contador"}, contador_instr, 32'(cnt));
        check({tag, ".motivo"}, 32'(motivo_parada), 32'(mot));
        check({tag, ".sat_estado"}, 32'(s_st), 32'(st));
        check({tag, ".sat_contador"}, 32'(s_cnt), 32'((cnt > 7) ? 7 : cnt));
    endtask

    task automatic release_and_hold(input string tag);
        @(negedge clk);
        reset   = 1'b1;
        cmd_run = 1'b1;
        for (int k = 1; k <= Hold; k++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_rd"}, 32'(reset_datapath), (k < Hold) ? 32'd1 : 32'd0);
            check({tag, ".hold_estado"}, 32'(estado), (k < Hold) ? 32'd0 : 32'd1);
            if (k == Hold - 1) cmd_run = 1'b0;
        end
        check({tag, ".hold_en"}, 32'(habilita_pc), 32'd0);
        check({tag, ".hold_cnt"}, contador_instr, 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        bit run, step, halt;
        logic [31:0] instr, pc;
        bit bpv;
        int st;
        bit en;
        int cnt;
        int mot;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit h, logic [31:0] ins, logic [31:0] pc, bit bv,
                                int st, bit en, int cnt, int mot);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.instr = ins; v.pc = pc; v.bpv = bv;
        v.st = st; v.en = en; v.cnt = cnt; v.mot = mot;
        return v;
    endfunction

    vec_t tbl [NV];
    logic [31:0] mem [32];

    // Behavioural model state
    int m_mode, m_hold, m_ret, m_cause, m_pc;
    bit m_resumed;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic int c0 = (Bp != 0) ? 11 : 13;
        tbl[0]  = mk(1, 0, 0, Nop,    0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, Nop,    0, 0, 2, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, Nop,    0, 0, 2, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0, Nop,    0, 0, 2, 1, 2, 0);
        tbl[4]  = mk(0, 0, 0, Nop,    0, 0, 2, 1, 3, 0);
        tbl[5]  = mk(0, 0, 1, Nop,    0, 0, 2, 1, 4, 0);
        tbl[6]  = mk(0, 0, 0, Nop,    0, 0, 4, 0, 5, 1);
        tbl[7]  = mk(0, 1, 0, Ebreak, 0, 0, 4, 0, 5, 1);
        tbl[8]  = mk(0, 0, 0, Ebreak, 0, 0, 3, 1, 5, 0);
        tbl[9]  = mk(0, 0, 0, Nop,    0, 0, 1, 0, 6, 0);
        tbl[10] = mk(1, 0, 0, Nop,    0, 0, 1, 0, 6, 0);
        tbl[11] = mk(0, 0, 0, Ebreak, 0, 0, 2, 0, 6, 0);
        tbl[12] = mk(0, 0, 0, Ebreak, 0, 0, 4, 0, 6, 2);
        tbl[13] = mk(1, 0, 0, Ebreak, 0, 0, 4, 0, 6, 2);
        tbl[14] = mk(0, 0, 0, Ebreak, 0, 0, 2, 1, 6, 0);
        tbl[15] = mk(0, 0, 0, Ecall,  0, 0, 2, 0, 7, 0);
        tbl[16] = mk(0, 0, 1, Ecall,  0, 0, 4, 0, 7, 2);
        tbl[17] = mk(1, 1, 0, Ecall,  0, 0, 4, 0, 7, 2);
        tbl[18] = mk(0, 0, 1, Ecall,  0, 0, 3, 1, 7, 0);
        tbl[19] = mk(1, 1, 0, Nop,    0, 0, 1, 0, 8, 0);
        tbl[20] = mk(0, 0, 0, Nop,    0, 0, 3, 1, 8, 0);
        tbl[21] = mk(1, 0, 0, Nop,    0, 0, 1, 0, 9, 0);
        tbl[22] = mk(1, 0, 1, Nop,    0, 0, 2, 1, 9, 0);
        tbl[23] = mk(0, 0, 0, Nop,    0, 0, 4, 0, 10, 1);
        tbl[24] = mk(1, 0, 0, Nop,    8, 1, 4, 0, 10, 1);
        tbl[25] = mk(0, 0, 0, Nop,    8, 1, 2, 1, 10, 0);
        tbl[26] = mk(0, 0, 0, Nop,    8, 1, 2, Bp == 0, 11, 0);
        tbl[27] = mk(0, 0, 1, Nop,    8, 1, (Bp != 0) ? 4 : 2, Bp == 0,
                     (Bp != 0) ? 11 : 12, (Bp != 0) ? 3 : 0);
        tbl[28] = mk(1, 0, 0, Ebreak, 8, 1, 4, 0, c0, (Bp != 0) ? 3 : 1);
        tbl[29] = mk(0, 0, 0, Ebreak, 8, 1, 2, 1, c0, 0);
        tbl[30] = mk(0, 0, 0, Ebreak, 8, 1, 2, 0, c0 + 1, 0);
        tbl[31] = mk(0, 0, 0, Nop,    0, 0, 4, 0, c0 + 1, 2);

        reset = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
        bp_addr = 32'd8; bp_valido = 1'b0; pc_atual = '0; instrucao = Nop;

        repeat (3) @(negedge clk);
        #1;
        check_all("reset", 0, 0, 1, 0, 0);
        release_and_hold("rel0");

        for (int i = 0; i < NV; i++) begin
            cmd_run = tbl[i].run; cmd_step = tbl[i].step; cmd_halt = tbl[i].halt;
            instrucao = tbl[i].instr; pc_atual = tbl[i].pc; bp_valido = tbl[i].bpv;
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].en, 0, tbl[i].cnt, tbl[i].mot);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of free-running execution
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        repeat (2) @(negedge clk);
        check("midrun.pre_estado", 32'(estado), 32'd2);
        check("midrun.pre_en", 32'(habilita_pc), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all("midrun", 0, 0, 1, 0, 0);
        release_and_hold("rel1");

        // Randomized run against the behavioural model
        for (int i = 0; i < 32; i++) begin
            automatic int r = $urandom_range(0, 15);
            mem[i] = (r == 0) ? Ebreak : (r == 1) ? Ecall : Nop;
        end
        m_mode = MIdle; m_hold = Hold; m_ret = 0; m_cause = 0; m_pc = 0; m_resumed = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            automatic int r = $urandom_range(0, 11);
            automatic bit is_trap, is_bp, stop_now, commit, resumed_n;
            automatic int old_mode;
            cmd_run  = (r == 0);
            cmd_step = (r == 1);
            cmd_halt = (r == 2);
            if ($urandom_range(0, 15) == 0) bp_addr = 32'($urandom_range(0, 31)) << 2;
            bp_valido = $urandom_range(0, 1) != 0;
            pc_atual  = 32'(m_pc);
            instrucao = mem[m_pc / 4];
            #1;
            is_trap  = (instrucao == Ebreak) || (instrucao == Ecall);
            is_bp    = (Bp != 0) && bp_valido && (pc_atual == bp_addr);
            stop_now = (is_trap || is_bp) && !m_resumed;
            commit   = ((m_mode == MRun) || (m_mode == MStep)) && !stop_now;
            check_all($sformatf("rand%0d", cyc), m_mode, commit, m_mode == MInit, m_ret, m_cause);

            old_mode  = m_mode;
            resumed_n = 1'b0;
            case (m_mode)
                MInit: if (m_hold == 1) m_mode = MIdle; else m_hold--;
                MIdle: begin
                    if (cmd_step) m_mode = MStep;
                    else if (cmd_run) m_mode = MRun;
                end
                MRun: begin
                    if (stop_now) begin m_mode = MHalted; m_cause = is_trap ? 2 : 3; end
                    else if (cmd_halt) begin m_mode = MHalted; m_cause = 1; end
                end
                MStep: begin
                    if (stop_now) begin m_mode = MHalted; m_cause = is_trap ? 2 : 3; end
                    else m_mode = MIdle;
                end
                MHalted: begin
                    if (cmd_step || cmd_run) begin
                        m_mode = cmd_step ? MStep : MRun;
                        m_cause = 0;
                        resumed_n = 1'b1;
                    end
                end
                default: m_mode = MInit;
            endcase
            m_resumed = resumed_n;
            if (commit) m_ret++;
            m_pc = (old_mode == MInit) ? 0 : commit ? ((m_pc + 4) % 128) : m_pc;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
